// File: rtl/calc_pkg.sv
// Shared types for the RPN calculator: Enter-button conditioner state encoding.
package calc_pkg;

  typedef enum logic [2:0] {
    S_ARM        = 3'd0,
    S_IDLE       = 3'd1,
    S_PRESS_DB   = 3'd2,
    S_HELD       = 3'd3,
    S_RELEASE_DB = 3'd4
  } btn_state_t;

endpackage

// File: rtl/sync_ff.sv
// Generic multi-flop synchroniser for an asynchronous single-bit input.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/enter_pulse_conditioner.sv
// Enter push-button conditioner: synchronise, debounce, one strobe per press
// plus a one-shot long-hold strobe.
module enter_pulse_conditioner
  import calc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic enter_pulse,
  output logic long_pulse,
  output logic btn_level
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("LONG_CYCLES must be >= 1");
  end

  logic s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (s)
  );

  btn_state_t        state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_done_q, long_done_d;
  logic              enter_d, long_d, level_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_ARM;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      enter_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      btn_level   <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_done_q <= long_done_d;
      enter_pulse <= enter_d;
      long_pulse  <= long_d;
      btn_level   <= level_d;
    end
  end

  // Next-state, counters and registered-output next values.
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_done_d = long_done_q;
    enter_d     = 1'b0;
    long_d      = 1'b0;
    level_d     = btn_level;

    case (state_q)
      // Requires a stable release first, so a button held through reset is ignored.
      S_ARM: begin
        if (s) begin
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
          if (db_cnt_q == DB_LAST) state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (s) begin
          state_d  = S_PRESS_DB;
          db_cnt_d = '0;
        end
      end
      S_PRESS_DB: begin
        if (!s) begin
          state_d = S_IDLE;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
          if (db_cnt_q == DB_LAST) begin
            state_d     = S_HELD;
            enter_d     = 1'b1;
            level_d     = 1'b1;
            hold_cnt_d  = '0;
            long_done_d = 1'b0;
          end
        end
      end
      S_HELD: begin
        if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (hold_cnt_q == LONG_LAST && !long_done_q) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end
        if (!s) begin
          state_d  = S_RELEASE_DB;
          db_cnt_d = '0;
        end
      end
      S_RELEASE_DB: begin
        if (s) begin
          state_d = S_HELD;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
          if (db_cnt_q == DB_LAST) begin
            state_d = S_IDLE;
            level_d = 1'b0;
          end
        end
      end
      default: begin
        state_d     = S_ARM;
        db_cnt_d    = '0;
        hold_cnt_d  = '0;
        long_done_d = 1'b0;
        level_d     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_enter_pulse_conditioner.sv
// Directed bench for enter_pulse_conditioner (SYNC=2, DEBOUNCE=4, LONG=20).
module tb_enter_pulse_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic btn_raw;
  logic enter_pulse, long_pulse, btn_level;

  int n_tests = 0;
  int n_fail  = 0;
  int n_enter = 0;
  int n_long  = 0;
  int n_level = 0;
  int base_enter, base_long, base_level;

  enter_pulse_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .enter_pulse (enter_pulse),
    .long_pulse  (long_pulse),
    .btn_level   (btn_level)
  );

  always #5 clk = ~clk;

  // Pulse/level occupancy counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (enter_pulse) n_enter++;
    if (long_pulse)  n_long++;
    if (btn_level)   n_level++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    base_enter = n_enter;
    base_long  = n_long;
    base_level = n_level;
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 1'b0;
    tick(3);
    check("rst_enter", 32'(enter_pulse), 32'd0);
    check("rst_long",  32'(long_pulse),  32'd0);
    check("rst_level", 32'(btn_level),   32'd0);
    reset = 1'b0;

    // 1. clean press: pulse registered on the 7th edge counting the first sampling edge
    tick(10);
    snap();
    btn_raw = 1'b1;
    tick(6);
    check("t1_enter_early", 32'(enter_pulse), 32'd0);
    check("t1_level_early", 32'(btn_level),   32'd0);
    tick(1);
    check("t1_enter", 32'(enter_pulse), 32'd1);
    check("t1_level", 32'(btn_level),   32'd1);
    tick(1);
    check("t1_enter_width", 32'(enter_pulse), 32'd0);

    // 3. long hold: long_pulse 20 edges after the enter_pulse edge, once
    tick(18);
    check("t3_long_early", 32'(long_pulse), 32'd0);
    tick(1);
    check("t3_long", 32'(long_pulse), 32'd1);
    tick(1);
    check("t3_long_width", 32'(long_pulse), 32'd0);
    tick(30);
    check("t3_long_count",  32'(n_long - base_long),   32'd1);
    check("t3_enter_count", 32'(n_enter - base_enter), 32'd1);

    // 4. release bounce, then final release
    snap();
    btn_raw = 1'b0; tick(2);
    btn_raw = 1'b1; tick(2);
    btn_raw = 1'b0;
    tick(6);
    check("t4_level_held", 32'(btn_level), 32'd1);
    tick(1);
    check("t4_level_fall", 32'(btn_level), 32'd0);
    check("t4_no_enter", 32'(n_enter - base_enter), 32'd0);
    tick(10);

    // 2. press bounce shorter than the debounce window
    snap();
    for (int i = 0; i < 4; i++) begin
      btn_raw = (i % 2 == 0);
      tick(2);
    end
    btn_raw = 1'b0;
    tick(12);
    check("t2_no_enter", 32'(n_enter - base_enter), 32'd0);
    check("t2_no_level", 32'(n_level - base_level), 32'd0);

    // 5. held through reset: ignored until released and re-pressed
    btn_raw = 1'b1;
    reset   = 1'b1;
    tick(3);
    reset = 1'b0;
    snap();
    tick(50);
    check("t5_no_enter", 32'(n_enter - base_enter), 32'd0);
    check("t5_no_level", 32'(btn_level), 32'd0);
    btn_raw = 1'b0;
    tick(10);
    btn_raw = 1'b1;
    tick(10);
    check("t5_enter_count", 32'(n_enter - base_enter), 32'd1);
    check("t5_level", 32'(btn_level), 32'd1);

    // 6. reset one cycle before long_pulse would be registered (due at edge 20 after enter)
    tick(15);
    check("t6_long_not_yet", 32'(n_long - base_long), 32'd0);
    reset = 1'b1;
    tick(1);
    check("t6_enter", 32'(enter_pulse), 32'd0);
    check("t6_long",  32'(long_pulse),  32'd0);
    check("t6_level", 32'(btn_level),   32'd0);
    reset = 1'b0;
    tick(30);
    check("t6_no_long",  32'(n_long - base_long),   32'd0);
    check("t6_no_enter", 32'(n_enter - base_enter), 32'd1);
    btn_raw = 1'b0;
    tick(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
